// File: rtl/mips_mc_control_pkg.sv
// Shared opcodes, funct codes, FSM state encodings and mux select encodings
// for the multi-cycle MIPS control path.
package mips_mc_control_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD   = 6'h20;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // PC source select
  localparam logic PCSRC_ALU  = 1'b0;
  localparam logic PCSRC_JUMP = 1'b1;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_WB_LD    = 4'd10,
    S_HALT     = 4'd11
  } state_e;

endpackage

// File: rtl/mips_mc_control_mem_wait_timer.sv
// Counts consecutive wait cycles of an outstanding memory request and flags
// expiry once TIMEOUT waits have elapsed without mem_ready.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,   // a memory state is being entered next cycle
  input  logic req,     // a memory request is outstanding this cycle
  input  logic ready,   // memory completes this cycle
  output logic expire
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // Expiry is seen in the cycle where the count already holds TIMEOUT, so a
  // ready arriving in that same cycle still completes the transfer.
  assign expire = (TIMEOUT != 0) && req && !ready && (cnt == LIM);

  // Wait-cycle counter: cleared on entry and on completion, saturates at LIM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (start || ready)          cnt <= '0;
    else if (req && (cnt != LIM))     cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and
// writeback through a single shared ALU and memory port.
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_opcode,
  output logic [5:0] alu_funct,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   fault_q, fault_d;
  logic   mem_phase, tmr_start, tmo;

  // Memory phase is decoded from the registered state alone so the timer
  // never depends on the combinational output block.
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
  assign tmr_start = (state_d != state_q) &&
                     ((state_d == S_FETCH) || (state_d == S_MEM_RD) ||
                      (state_d == S_MEM_WR));

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tmr_start),
    .req    (mem_phase),
    .ready  (mem_ready),
    .expire (tmo)
  );

  assign state = state_q;
  assign fault = fault_q;

  // State and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and control outputs; only FETCH/MEM_WR strobes look at mem_ready.
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_opcode = 6'h00;
    alu_funct  = 6'h00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        alu_opcode = OP_ADDIU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_R && funct == FN_ADD)        state_d = S_EXEC_R;
        else if (opcode == OP_ADDIU)                  state_d = S_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_MEM_ADDR;
        else if (opcode == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_opcode = OP_R;
        alu_funct  = FN_ADD;
        state_d    = S_WB_R;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_opcode = OP_ADDIU;
        if (state_q == S_EXEC_I)  state_d = S_WB_I;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB_LD;
        else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (tmo) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Cycle-accurate scoreboard bench for the multi-cycle control FSM.
module tb_mips_mc_control;
  import mips_mc_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0] alu_src_b;
  logic [5:0] alu_opcode, alu_funct;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, fault;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_mc_control #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_opcode(alu_opcode),
    .alu_funct(alu_funct), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .fault(fault),
    .state(state)
  );

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_opcode, alu_funct;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, fault;
    logic [3:0] state;
  } obs_t;

  obs_t obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_opcode, alu_funct, reg_write, reg_dst,
                mem_to_reg, instr_done, fault, state};

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected control word for one cycle in state s.
  function automatic obs_t expv(state_e s, logic rdy, logic [5:0] op, logic flt);
    obs_t e;
    e = '0;
    e.state = s;
    e.fault = flt;
    case (s)
      S_FETCH: begin
        e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_opcode = 6'h09;
        e.ir_write = rdy; e.pc_write = rdy;
      end
      S_DECODE: if (op == 6'h02) begin
        e.pc_write = 1'b1; e.pc_src = 1'b1; e.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd0; e.alu_opcode = 6'h00; e.alu_funct = 6'h20;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_opcode = 6'h09;
      end
      S_MEM_RD: begin e.mem_req = 1'b1; e.iord = 1'b1; end
      S_MEM_WR: begin
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.iord = 1'b1; e.instr_done = rdy;
      end
      S_WB_R:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1; end
      S_WB_I:  begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
      S_WB_LD: begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // Compare every cycle that has an expectation queued.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check($sformatf("cyc_st%0d", e.state), 32'(obs), 32'(e));
    end
  end

  task automatic step(state_e s, logic rdy, logic flt, logic [5:0] op, logic [5:0] fn);
    @(posedge clk); #1;
    opcode = op; funct = fn; mem_ready = rdy;
    exp_q.push_back(expv(s, rdy, op, flt));
  endtask

  task automatic hold_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b0;
    #1 check("rst_outs_async", 32'(obs), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_outs_held", 32'(obs), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(expv(S_RESET, 1'b0, opcode, 1'b0));
  endtask

  // One instruction from FETCH entry with fw fetch waits and mw data waits.
  task automatic instr(logic [5:0] op, logic [5:0] fn, int fw, int mw);
    for (int i = 0; i < fw; i++) step(S_FETCH, 1'b0, 1'b0, op, fn);
    step(S_FETCH, 1'b1, 1'b0, op, fn);
    step(S_DECODE, 1'b0, 1'b0, op, fn);
    case (op)
      6'h00: begin step(S_EXEC_R, 1'b0, 1'b0, op, fn); step(S_WB_R, 1'b0, 1'b0, op, fn); end
      6'h09: begin step(S_EXEC_I, 1'b0, 1'b0, op, fn); step(S_WB_I, 1'b0, 1'b0, op, fn); end
      6'h23: begin
        step(S_MEM_ADDR, 1'b0, 1'b0, op, fn);
        for (int i = 0; i < mw; i++) step(S_MEM_RD, 1'b0, 1'b0, op, fn);
        step(S_MEM_RD, 1'b1, 1'b0, op, fn);
        step(S_WB_LD, 1'b0, 1'b0, op, fn);
      end
      6'h2B: begin
        step(S_MEM_ADDR, 1'b0, 1'b0, op, fn);
        for (int i = 0; i < mw; i++) step(S_MEM_WR, 1'b0, 1'b0, op, fn);
        step(S_MEM_WR, 1'b1, 1'b0, op, fn);
      end
      default: ;
    endcase
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", 32'(obs), 32'd0);
    release_reset();

    // Normal instruction mix
    instr(6'h00, 6'h20, 0, 0);   // ADD, 4 cycles
    instr(6'h09, 6'h11, 2, 0);   // ADDIU with fetch waits
    instr(6'h23, 6'h00, 0, 3);   // LW, 3 data waits -> 8 cycles
    instr(6'h2B, 6'h00, 0, 1);   // SW, 1 data wait
    instr(6'h02, 6'h3F, 0, 0);   // J, 2 cycles
    instr(6'h02, 6'h00, 1, 0);   // back-to-back J
    instr(6'h23, 6'h00, 0, 0);   // LW zero wait, 5 cycles

    // Illegal opcode: HALT forever, mem_ready ignored
    step(S_FETCH, 1'b1, 1'b0, 6'h3F, 6'h20);
    step(S_DECODE, 1'b0, 1'b0, 6'h3F, 6'h20);
    for (int i = 0; i < 20; i++) step(S_HALT, 1'(i), 1'b1, 6'h00, 6'h20);

    // R-type with unsupported funct
    hold_reset();
    release_reset();
    step(S_FETCH, 1'b1, 1'b0, 6'h00, 6'h22);
    step(S_DECODE, 1'b0, 1'b0, 6'h00, 6'h22);
    for (int i = 0; i < 4; i++) step(S_HALT, 1'b0, 1'b1, 6'h00, 6'h22);

    // Fetch timeout: 15 waits pass, the cycle holding count 15 expires
    hold_reset();
    release_reset();
    for (int i = 0; i < 16; i++) step(S_FETCH, 1'b0, 1'b0, 6'h02, 6'h00);
    for (int i = 0; i < 5; i++) step(S_HALT, 1'b0, 1'b1, 6'h02, 6'h00);

    // Ready on the expiry cycle wins
    hold_reset();
    release_reset();
    for (int i = 0; i < 15; i++) step(S_FETCH, 1'b0, 1'b0, 6'h02, 6'h00);
    step(S_FETCH, 1'b1, 1'b0, 6'h02, 6'h00);
    step(S_DECODE, 1'b0, 1'b0, 6'h02, 6'h00);
    instr(6'h00, 6'h20, 14, 0);  // counter restarted on FETCH entry

    // Reset in the middle of a store
    step(S_FETCH, 1'b1, 1'b0, 6'h2B, 6'h00);
    step(S_DECODE, 1'b0, 1'b0, 6'h2B, 6'h00);
    step(S_MEM_ADDR, 1'b0, 1'b0, 6'h2B, 6'h00);
    step(S_MEM_WR, 1'b0, 1'b0, 6'h2B, 6'h00);
    #6 rst_n = 1'b0;
    #1 check("rst_mid_memwr", 32'(obs), 32'd0);
    @(posedge clk); #1 check("rst_mid_hold", 32'(obs), 32'd0);
    release_reset();
    instr(6'h09, 6'h00, 0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
